// File: rtl/riscv_core_completion_queue_if.sv
// rtl/riscv_core_completion_queue_if.sv - completion-event and ROB completion-request bundle for the completion queue
interface riscv_core_completion_queue_if #(
  parameter int DEPTH  = 8,
  parameter int SLOT_W = 5
);
  logic                    cmpl_val_0;
  logic                    cmpl_val_1;
  logic                    cmpl_val_2;
  logic [SLOT_W-1:0]       cmpl_slot_0;
  logic [SLOT_W-1:0]       cmpl_slot_1;
  logic [SLOT_W-1:0]       cmpl_slot_2;
  logic                    flush;
  logic                    cq_ready;
  logic                    ROB_commit_req_A;
  logic [SLOT_W-1:0]       ROB_commit_req_slot_A;
  logic                    ROB_commit_req_B;
  logic [SLOT_W-1:0]       ROB_commit_req_slot_B;
  logic [$clog2(DEPTH):0]  cq_count;
  logic                    cq_overflow;

  modport master (
    output cmpl_val_0, cmpl_val_1, cmpl_val_2,
    output cmpl_slot_0, cmpl_slot_1, cmpl_slot_2, flush,
    input  cq_ready, ROB_commit_req_A, ROB_commit_req_slot_A,
    input  ROB_commit_req_B, ROB_commit_req_slot_B, cq_count, cq_overflow
  );

  modport slave (
    input  cmpl_val_0, cmpl_val_1, cmpl_val_2,
    input  cmpl_slot_0, cmpl_slot_1, cmpl_slot_2, flush,
    output cq_ready, ROB_commit_req_A, ROB_commit_req_slot_A,
    output ROB_commit_req_B, ROB_commit_req_slot_B, cq_count, cq_overflow
  );
endinterface

// File: rtl/riscv_core_completion_queue.sv
// rtl/riscv_core_completion_queue.sv - 3-in/2-out completion FIFO feeding the ROB
// Optional zero-latency bypass when empty: CQ_BYPASS_EN.
module riscv_core_completion_queue #(
  parameter int DEPTH  = 8,
  parameter int SLOT_W = 5
) (
  input logic                          clk,
  input logic                          reset,
  riscv_core_completion_queue_if.slave cq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SLOT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head, tail, head_p1;
  logic [CW-1:0]     count;
  logic              overflow;

  logic [2:0]        val;
  logic [SLOT_W-1:0] slot [3];
  logic [CW-1:0]     rank [3];
  logic [CW-1:0]     n_valid, skip, n_enq, n_deq;
  logic              ready, accept, byp, fifo_a, fifo_b;

  assign val     = {cq.cmpl_val_2, cq.cmpl_val_1, cq.cmpl_val_0};
  assign slot[0] = cq.cmpl_slot_0;
  assign slot[1] = cq.cmpl_slot_1;
  assign slot[2] = cq.cmpl_slot_2;

  // rank = number of older valid inputs this cycle, so valid inputs pack without gaps
  assign rank[0] = '0;
  assign rank[1] = CW'(val[0]);
  assign rank[2] = CW'(val[0]) + CW'(val[1]);
  assign n_valid = rank[2] + CW'(val[2]);

  assign ready   = count <= CW'(DEPTH - 3);
  assign accept  = ready && !cq.flush;
  assign fifo_a  = count != '0;
  assign fifo_b  = count > CW'(1);
  assign head_p1 = head + AW'(1);
  assign n_deq   = CW'(fifo_a) + CW'(fifo_b);

`ifdef CQ_BYPASS_EN
  assign byp = (count == '0) && !cq.flush;
`else
  assign byp = 1'b0;
`endif
  // The first two valid inputs go straight out when bypassing; only the rest are stored
  assign skip  = byp ? CW'(2) : '0;
  assign n_enq = !accept ? '0 : (n_valid > skip) ? (n_valid - skip) : '0;

  always_comb begin
    cq.ROB_commit_req_A      = fifo_a;
    cq.ROB_commit_req_B      = fifo_b;
    cq.ROB_commit_req_slot_A = fifo_a ? mem[head] : '0;
    cq.ROB_commit_req_slot_B = fifo_b ? mem[head_p1] : '0;
`ifdef CQ_BYPASS_EN
    if (byp) begin
      cq.ROB_commit_req_A      = n_valid != '0;
      cq.ROB_commit_req_B      = n_valid > CW'(1);
      cq.ROB_commit_req_slot_A = val[0] ? slot[0] : val[1] ? slot[1] : val[2] ? slot[2] : '0;
      cq.ROB_commit_req_slot_B = (n_valid < CW'(2)) ? '0 :
                                 (val[0] && val[1]) ? slot[1] : slot[2];
    end
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (accept && val[i] && rank[i] >= skip)
        mem[tail + AW'(rank[i] - skip)] <= slot[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (cq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_deq);
      tail  <= tail + AW'(n_enq);
      count <= count + n_enq - n_deq;
      if (!ready && |val)
        overflow <= 1'b1;
    end
  end

  assign cq.cq_ready    = ready;
  assign cq.cq_count    = count;
  assign cq.cq_overflow = overflow;
endmodule

// File: tb/tb_riscv_core_completion_queue.sv
// tb/tb_riscv_core_completion_queue.sv - scoreboard bench for the completion queue
module tb_riscv_core_completion_queue;
  localparam int DEPTH  = 8;
  localparam int SLOT_W = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [SLOT_W-1:0] exp_q [$];

  riscv_core_completion_queue_if #(.DEPTH(DEPTH), .SLOT_W(SLOT_W)) cq_bus ();

  riscv_core_completion_queue #(.DEPTH(DEPTH), .SLOT_W(SLOT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .cq    (cq_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [SLOT_W-1:0] s);
    logic [SLOT_W-1:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got slot %0d expected no request", name, s);
    end else begin
      e = exp_q.pop_front();
      check(name, s, e);
    end
  endtask

  // Monitor: every issued request must match the oldest outstanding expected slot
  always @(negedge clk) begin
    if (reset) begin
      if (cq_bus.ROB_commit_req_A)
        pop_check("slot_A", cq_bus.ROB_commit_req_slot_A);
      if (cq_bus.ROB_commit_req_B) begin
        check("req_B_implies_A", cq_bus.ROB_commit_req_A, 1);
        pop_check("slot_B", cq_bus.ROB_commit_req_slot_B);
      end
    end
  end

  task automatic drive(input logic v0, input logic [SLOT_W-1:0] s0,
                       input logic v1, input logic [SLOT_W-1:0] s1,
                       input logic v2, input logic [SLOT_W-1:0] s2,
                       input logic fl, input logic push);
    cq_bus.cmpl_val_0  = v0;
    cq_bus.cmpl_slot_0 = s0;
    cq_bus.cmpl_val_1  = v1;
    cq_bus.cmpl_slot_1 = s1;
    cq_bus.cmpl_val_2  = v2;
    cq_bus.cmpl_slot_2 = s2;
    cq_bus.flush       = fl;
    if (push) begin
      if (v0) exp_q.push_back(s0);
      if (v1) exp_q.push_back(s1);
      if (v2) exp_q.push_back(s2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic triple(input logic [SLOT_W-1:0] a, input logic [SLOT_W-1:0] b,
                        input logic [SLOT_W-1:0] c);
    drive(1, a, 1, b, 1, c, 0, 1);
  endtask

  initial begin
    cq_bus.cmpl_val_0 = 0; cq_bus.cmpl_val_1 = 0; cq_bus.cmpl_val_2 = 0;
    cq_bus.cmpl_slot_0 = 0; cq_bus.cmpl_slot_1 = 0; cq_bus.cmpl_slot_2 = 0;
    cq_bus.flush = 0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_req_A", cq_bus.ROB_commit_req_A, 0);
    check("rst_req_B", cq_bus.ROB_commit_req_B, 0);
    check("rst_slot_A", cq_bus.ROB_commit_req_slot_A, 0);
    check("rst_count", cq_bus.cq_count, 0);
    check("rst_ready", cq_bus.cq_ready, 1);
    check("rst_overflow", cq_bus.cq_overflow, 0);

    // Single completion, one-cycle latency
    drive(1, 5, 0, 0, 0, 0, 0, 1);
    check("single_req_A", cq_bus.ROB_commit_req_A, 1);
    check("single_slot_A", cq_bus.ROB_commit_req_slot_A, 5);
    check("single_req_B", cq_bus.ROB_commit_req_B, 0);
    check("single_count", cq_bus.cq_count, 1);
    idle();
    check("single_idle_req_A", cq_bus.ROB_commit_req_A, 0);
    check("single_idle_count", cq_bus.cq_count, 0);

    // Walk head to 7, then queue a pair that straddles the wrap
    for (int i = 0; i < 6; i++) drive(1, SLOT_W'(10 + i), 0, 0, 0, 0, 0, 1);
    idle();
    check("wrap_pre_count", cq_bus.cq_count, 0);
    drive(1, 30, 1, 31, 0, 0, 0, 1);
    check("wrap_req_A", cq_bus.ROB_commit_req_A, 1);
    check("wrap_req_B", cq_bus.ROB_commit_req_B, 1);
    check("wrap_slot_A", cq_bus.ROB_commit_req_slot_A, 30);
    check("wrap_slot_B", cq_bus.ROB_commit_req_slot_B, 31);
    idle();
    check("wrap_post_count", cq_bus.cq_count, 0);
    drive(0, 0, 1, 3, 1, 4, 0, 1);
    idle();

    // Burst of three full cycles
    triple(1, 2, 3);
    check("burst_count_1", cq_bus.cq_count, 3);
    triple(4, 5, 6);
    check("burst_count_2", cq_bus.cq_count, 4);
    triple(7, 8, 9);
    check("burst_count_3", cq_bus.cq_count, 5);
    check("burst_ready", cq_bus.cq_ready, 1);
    idle();
    check("burst_drain_1", cq_bus.cq_count, 3);
    idle();
    check("burst_drain_2", cq_bus.cq_count, 1);
    idle();
    check("burst_drain_3", cq_bus.cq_count, 0);

    // Overflow: fill to 6, then present a completion while not ready
    triple(1, 2, 3);
    triple(4, 5, 6);
    triple(7, 8, 9);
    triple(10, 11, 12);
    check("ovf_count_full", cq_bus.cq_count, 6);
    check("ovf_ready_low", cq_bus.cq_ready, 0);
    check("ovf_before", cq_bus.cq_overflow, 0);
    drive(0, 0, 0, 0, 1, 20, 0, 0);
    check("ovf_set", cq_bus.cq_overflow, 1);
    check("ovf_count_drop", cq_bus.cq_count, 4);
    idle();
    idle();
    check("ovf_drained", cq_bus.cq_count, 0);
    check("ovf_sticky", cq_bus.cq_overflow, 1);

    // Flush with a same-cycle completion
    triple(1, 2, 3);
    triple(4, 5, 6);
    triple(7, 8, 9);
    check("flush_pre_count", cq_bus.cq_count, 5);
    drive(1, 12, 0, 0, 0, 0, 1, 0);
    exp_q.delete();
    check("flush_count", cq_bus.cq_count, 0);
    check("flush_req_A", cq_bus.ROB_commit_req_A, 0);
    check("flush_req_B", cq_bus.ROB_commit_req_B, 0);
    idle();
    check("flush_idle_count", cq_bus.cq_count, 0);
    check("flush_keeps_ovf", cq_bus.cq_overflow, 1);

    // Asynchronous reset mid-operation
    triple(1, 2, 3);
    reset = 1'b0;
    #1;
    check("async_rst_count", cq_bus.cq_count, 0);
    check("async_rst_req_A", cq_bus.ROB_commit_req_A, 0);
    check("async_rst_ovf", cq_bus.cq_overflow, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("post_rst_ready", cq_bus.cq_ready, 1);
    drive(0, 0, 0, 0, 1, 7, 0, 1);
    check("post_rst_slot_A", cq_bus.ROB_commit_req_slot_A, 7);
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
